// File: rtl/fetch_stage.sv
// fetch_stage: samples the PC, reads instruction memory over req/ack and holds the word for decode.
module fetch_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  pc_stall,
    output logic                  fetch_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
    state_t state_q, state_d;
    logic mem_req_q, mem_req_d, valid_q, valid_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, ipc_q, ipc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic timeout;
    // The wait counter spans FETCH and DRAIN, so a flushed fetch still aborts in bounded time.
    assign timeout = !mem_ack && cnt_q == CW'(TIMEOUT - 1);
    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        cnt_d     = '0;
        case (state_q)
            IDLE: begin
                addr_d = pc;
                if (!flush) begin
                    state_d   = FETCH;
                    mem_req_d = 1'b1;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = flush ? IDLE : HOLD;
                    if (!flush) begin
                        instr_d = mem_rdata;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                    end
                end else if (timeout) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = flush ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                if (mem_ack || timeout) begin
                    mem_req_d = 1'b0;
                    err_d     = !mem_ack;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (instr_ready || flush) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            instr_q   <= '0;
            ipc_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end
    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign pc_stall    = !(state_q == HOLD && instr_ready && !flush);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, directed corner sequences and random stimulus against a transaction model.
module tb_fetch_stage;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 15;
    logic clk = 1'b0, reset = 1'b1;
    logic [AW-1:0] pc = '0;
    logic flush = 1'b0, mem_ack = 1'b0, instr_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic mem_req, instr_valid, pc_stall, fetch_err;
    logic [AW-1:0] mem_addr, instr_pc;
    logic [DW-1:0] instr;
    fetch_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .pc(pc), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_stall(pc_stall), .fetch_err(fetch_err)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0;
    // Model view: a request is either outstanding or not, an instruction is either held or not.
    bit m_req, m_valid, m_err, m_drop;
    logic [AW-1:0] m_addr, m_ipc;
    logic [DW-1:0] m_instr;
    int m_wait;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_req = 0; m_valid = 0; m_err = 0; m_drop = 0;
        m_addr = '0; m_ipc = '0; m_instr = '0; m_wait = 0;
    endtask
    task automatic model_step(input logic [AW-1:0] p, input logic f, a, input logic [DW-1:0] d, input logic r);
        m_err = 0;
        if (m_valid) begin
            if (r || f) m_valid = 0;
        end else if (!m_req) begin
            m_addr = p;
            m_drop = 0;
            m_wait = 0;
            if (!f) m_req = 1;
        end else if (a) begin
            m_req = 0;
            m_wait = 0;
            if (!m_drop && !f) begin
                m_valid = 1;
                m_instr = d;
                m_ipc = m_addr;
            end
        end else if (m_wait + 1 == TO) begin
            m_req = 0;
            m_err = 1;
            m_wait = 0;
        end else begin
            m_wait++;
            if (f) m_drop = 1;
        end
    endtask
    task automatic cycle(input logic [AW-1:0] p, input logic f, a, input logic [DW-1:0] d, input logic r,
                         output logic st);
        pc = p; flush = f; mem_ack = a; mem_rdata = d; instr_ready = r;
        #1 st = pc_stall;
        chk("pc_stall", pc_stall, 32'(!(m_valid && r && !f)));
        @(posedge clk);
        model_step(p, f, a, d, r);
        @(negedge clk);
        chk("mem_req", mem_req, 32'(m_req));
        chk("mem_addr", mem_addr, 32'(m_addr));
        chk("instr_valid", instr_valid, 32'(m_valid));
        chk("instr", instr, 32'(m_instr));
        chk("instr_pc", instr_pc, 32'(m_ipc));
        chk("fetch_err", fetch_err, 32'(m_err));
    endtask
    typedef struct {
        logic [AW-1:0] p; logic f; logic a; logic [DW-1:0] d; logic r;
        logic st; logic req; logic [AW-1:0] addr; logic v; logic [DW-1:0] ins; logic [AW-1:0] ipc;
    } vec_t;
    vec_t tv[$];
    logic st;
    int ak;
    initial begin
        tv.push_back('{16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000});
        tv.push_back('{16'h0000, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000});
        tv.push_back('{16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1111, 16'h0000});
        tv.push_back('{16'h0004, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h1111, 16'h0000});
        tv.push_back('{16'h0004, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h1111, 16'h0000});
        tv.push_back('{16'h0004, 1'b0, 1'b1, 16'hA5A5, 1'b1, 1'b1, 1'b0, 16'h0004, 1'b1, 16'hA5A5, 16'h0004});
        tv.push_back('{16'h0004, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 16'hA5A5, 16'h0004});
        tv.push_back('{16'h0006, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b0, 16'hA5A5, 16'h0004});
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst instr", instr, 0);
        chk("rst instr_pc", instr_pc, 0);
        chk("rst instr_valid", instr_valid, 0);
        chk("rst fetch_err", fetch_err, 0);
        chk("rst pc_stall", pc_stall, 1);
        reset = 1'b0;
        foreach (tv[i]) begin
            cycle(tv[i].p, tv[i].f, tv[i].a, tv[i].d, tv[i].r, st);
            chk($sformatf("vec%0d stall", i), st, 32'(tv[i].st));
            chk($sformatf("vec%0d req", i), mem_req, 32'(tv[i].req));
            chk($sformatf("vec%0d addr", i), mem_addr, 32'(tv[i].addr));
            chk($sformatf("vec%0d valid", i), instr_valid, 32'(tv[i].v));
            chk($sformatf("vec%0d instr", i), instr, 32'(tv[i].ins));
            chk($sformatf("vec%0d ipc", i), instr_pc, 32'(tv[i].ipc));
        end
        // Backpressure: held word must not move and no new request may start.
        cycle(16'h0006, 0, 1, 16'hBEEF, 0, st);
        for (int k = 0; k < 5; k++) begin
            cycle(16'h0006, 0, 0, 16'h0000, 0, st);
            chk("bp stall", st, 1);
            chk("bp valid", instr_valid, 1);
            chk("bp instr", instr, 16'hBEEF);
            chk("bp req", mem_req, 0);
        end
        cycle(16'h0006, 0, 0, 16'h0000, 1, st);
        chk("bp accept", st, 0);
        // Flush with the ack still pending: drained word never reaches decode.
        cycle(16'h0008, 0, 0, 16'h0000, 0, st);
        cycle(16'h0008, 1, 0, 16'h0000, 0, st);
        for (int k = 0; k < 3; k++) begin
            cycle(16'h3333, 0, k == 2, 16'hDEAD, 1, st);
            chk("drain valid", instr_valid, 0);
            chk("drain req", mem_req, k != 2);
        end
        cycle(16'h3333, 0, 0, 16'h0000, 0, st);
        chk("jump addr", mem_addr, 16'h3333);
        chk("jump req", mem_req, 1);
        // Flush and ready together in HOLD: not an accept.
        cycle(16'h3333, 0, 1, 16'h1234, 0, st);
        cycle(16'h3333, 1, 0, 16'h0000, 1, st);
        chk("flush+ready stall", st, 1);
        chk("flush+ready valid", instr_valid, 0);
        cycle(16'h5000, 0, 0, 16'h0000, 0, st);
        chk("redirect addr", mem_addr, 16'h5000);
        // Timeout: TO unanswered cycles, one error pulse, then retry of the same address.
        for (int k = 1; k <= TO; k++) begin
            cycle(16'h5000, 0, 0, 16'h0000, 0, st);
            chk("to req", mem_req, k != TO);
            chk("to err", fetch_err, k == TO);
        end
        cycle(16'h5000, 0, 0, 16'h0000, 0, st);
        chk("retry req", mem_req, 1);
        chk("retry addr", mem_addr, 16'h5000);
        chk("retry err", fetch_err, 0);
        // Asynchronous reset in the middle of a fetch drops the request at once.
        #2 reset = 1'b1;
        #1 chk("async rst req", mem_req, 0);
        chk("async rst stall", pc_stall, 1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) ak = (n % 1000 == 0) ? 2 : 20;
            cycle(AW'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, ak - 1) == 0,
                  DW'($urandom), 1'($urandom_range(0, 1)), st);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
